// File: rtl/cpu_wait_pkg.sv
// Shared definitions for the cpu_wait core: FSM states, instruction field
// positions and default parameter values.
package cpu_wait_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_MAX_WAIT = 8;

  localparam int A_BIT      = 12;
  localparam int ZX_BIT     = 11;
  localparam int NX_BIT     = 10;
  localparam int ZY_BIT     = 9;
  localparam int NY_BIT     = 8;
  localparam int F_BIT      = 7;
  localparam int NO_BIT     = 6;
  localparam int DEST_A_BIT = 5;
  localparam int DEST_D_BIT = 4;
  localparam int DEST_M_BIT = 3;
  localparam int JLT_BIT    = 2;
  localparam int JEQ_BIT    = 1;
  localparam int JGT_BIT    = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_wait_alu.sv
// Hack-style ALU: optional zero/invert on each operand, add or and,
// optional output invert, plus zero and negative flags.
module alu
  import cpu_wait_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] f_s;

  // Operand conditioning, function select and output invert.
  always_comb begin
    x_s = zx ? {WIDTH{1'b0}} : x;
    x_s = nx ? ~x_s : x_s;
    y_s = zy ? {WIDTH{1'b0}} : y;
    y_s = ny ? ~y_s : y_s;
    f_s = f ? (x_s + y_s) : (x_s & y_s);
    out = no ? ~f_s : f_s;
  end

  assign zr = (out == {WIDTH{1'b0}});
  assign ng = out[WIDTH-1];

endmodule

// File: rtl/cpu_wait.sv
// Hack-style CPU core whose data-memory accesses wait on mem_ready; a wait
// longer than MAX_WAIT cycles parks the core in a sticky FAULT state.
module cpu_wait
  import cpu_wait_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic             instruction_valid,
  input  logic [WIDTH-1:0] in_m,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] out_m,
  output logic [WIDTH-1:0] address_m,
  output logic             memory_load,
  output logic             memory_read,
  output logic [WIDTH-1:0] pc,
  output logic             stall,
  output logic             fault
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    wait_cnt_r;
  logic [CW-1:0]    wait_cnt_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] d_next_s;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] alu_out_s;
  logic             zr_s;
  logic             ng_s;
  logic             is_c_s;
  logic             needs_mem_s;
  logic             active_s;
  logic             commit_s;
  logic             take_s;

  assign is_c_s      = instruction[WIDTH-1];
  assign needs_mem_s = is_c_s & (instruction[A_BIT] | instruction[DEST_M_BIT]);
  assign active_s    = instruction_valid & ((state_r == ST_RUN) | (state_r == ST_WAIT));
  assign commit_s    = active_s & (~needs_mem_s | mem_ready);
  assign y_s         = instruction[A_BIT] ? in_m : a_r;

  alu #(.WIDTH(WIDTH)) u_alu (
    .x  (d_r),
    .y  (y_s),
    .zx (instruction[ZX_BIT]),
    .nx (instruction[NX_BIT]),
    .zy (instruction[ZY_BIT]),
    .ny (instruction[NY_BIT]),
    .f  (instruction[F_BIT]),
    .no (instruction[NO_BIT]),
    .out(alu_out_s),
    .zr (zr_s),
    .ng (ng_s)
  );

  assign take_s = is_c_s & ((instruction[JLT_BIT] & ng_s) |
                            (instruction[JEQ_BIT] & zr_s) |
                            (instruction[JGT_BIT] & ~ng_s & ~zr_s));

  assign out_m       = alu_out_s;
  assign address_m   = a_r;
  assign pc          = pc_r;
  assign memory_load = active_s & is_c_s & instruction[DEST_M_BIT];
  assign memory_read = active_s & is_c_s & instruction[A_BIT];
  assign stall       = active_s & needs_mem_s & ~mem_ready;
  assign fault       = (state_r == ST_FAULT);

  // Wait-state FSM: count memory wait cycles, trap on timeout.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (instruction_valid && needs_mem_s && !mem_ready) begin
          state_next_s    = ST_WAIT;
          wait_cnt_next_s = CNT_ONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_next_s    = ST_RUN;
          wait_cnt_next_s = {CW{1'b0}};
        end else if (wait_cnt_r == CNT_MAX) begin
          state_next_s = ST_FAULT;
        end else begin
          wait_cnt_next_s = wait_cnt_r + CNT_ONE;
        end
      end
      ST_FAULT: state_next_s = ST_FAULT;
      default:  state_next_s = ST_FAULT;
    endcase
  end

  // Commit datapath: A/D destinations and next program counter.
  always_comb begin
    a_next_s  = a_r;
    d_next_s  = d_r;
    pc_next_s = pc_r + PC_ONE;
    if (is_c_s) begin
      if (instruction[DEST_A_BIT]) a_next_s = alu_out_s;
      else a_next_s = a_r;
      if (instruction[DEST_D_BIT]) d_next_s = alu_out_s;
      else d_next_s = d_r;
      if (take_s) pc_next_s = a_r;
      else pc_next_s = pc_r + PC_ONE;
    end else begin
      a_next_s = {1'b0, instruction[WIDTH-2:0]};
    end
  end

  // State, wait counter and architectural registers; reset wins over all.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= {CW{1'b0}};
      a_r        <= {WIDTH{1'b0}};
      d_r        <= {WIDTH{1'b0}};
      pc_r       <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      if (commit_s) begin
        a_r  <= a_next_s;
        d_r  <= d_next_s;
        pc_r <= pc_next_s;
      end
    end
  end

endmodule

// File: tb/tb_cpu_wait.sv
// Scoreboard bench for cpu_wait: a mnemonic-level reference model predicts each
// instruction's visible effects; a negedge monitor compares them when the core commits.
module tb_cpu_wait;

  localparam int W  = 24;
  localparam int MW = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] instruction;
  logic         instruction_valid;
  logic [W-1:0] in_m;
  logic         mem_ready;
  logic [W-1:0] out_m;
  logic [W-1:0] address_m;
  logic         memory_load;
  logic         memory_read;
  logic [W-1:0] pc;
  logic         stall;
  logic         fault;

  always #5 clock = ~clock;

  cpu_wait #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clock            (clock),
    .reset            (reset),
    .instruction      (instruction),
    .instruction_valid(instruction_valid),
    .in_m             (in_m),
    .mem_ready        (mem_ready),
    .out_m            (out_m),
    .address_m        (address_m),
    .memory_load      (memory_load),
    .memory_read      (memory_read),
    .pc               (pc),
    .stall            (stall),
    .fault            (fault)
  );

  typedef struct {
    logic         chk_out;
    logic [W-1:0] out_m;
    logic [W-1:0] addr;
    logic [W-1:0] pc;
    logic         ml;
    logic         mr;
    int           stalls;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  int           stall_seen = 0;
  logic [W-1:0] ma, md, mpc;

  // Operation indices: 0:0 1:1 2:-1 3:D 4:Y 5:!D 6:!Y 7:-D 8:-Y 9:D+1 10:Y+1
  // 11:D-1 12:Y-1 13:D+Y 14:D-Y 15:Y-D 16:D&Y 17:D|Y  (Y is A or M)
  function automatic logic [5:0] comp_code(input int op);
    case (op)
      0: return 6'b101010;  1: return 6'b111111;  2: return 6'b111010;
      3: return 6'b001100;  4: return 6'b110000;  5: return 6'b001101;
      6: return 6'b110001;  7: return 6'b001111;  8: return 6'b110011;
      9: return 6'b011111; 10: return 6'b110111; 11: return 6'b001110;
      12: return 6'b110010; 13: return 6'b000010; 14: return 6'b010011;
      15: return 6'b000111; 16: return 6'b000000; 17: return 6'b010101;
      default: return 6'b101010;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] d, input logic [W-1:0] y);
    case (op)
      0: return '0;         1: return W'(1);       2: return '1;
      3: return d;          4: return y;           5: return ~d;
      6: return ~y;         7: return -d;          8: return -y;
      9: return d + W'(1); 10: return y + W'(1);  11: return d - W'(1);
      12: return y - W'(1); 13: return d + y;      14: return d - y;
      15: return y - d;     16: return d & y;      17: return d | y;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ma = '0; md = '0; mpc = '0;
  endtask

  // Issue one instruction, predict its effects, hold it until it commits.
  task automatic run_instr(input logic is_c, input logic [W-1:0] lit, input logic a,
                           input int op, input logic [2:0] dest, input logic [2:0] jmp,
                           input int lat, input logic [W-1:0] mval);
    exp_t         e;
    logic [W-1:0] res;
    logic [W-15:0] ign;
    logic         nm;
    logic         take;
    ign = (W-14)'($urandom);
    res = ref_op(op, md, a ? mval : ma);
    nm  = is_c && (a || dest[0]);
    e.chk_out = is_c;
    e.out_m   = res;
    e.addr    = ma;
    e.pc      = mpc;
    e.ml      = is_c && dest[0];
    e.mr      = is_c && a;
    e.stalls  = nm ? lat : 0;
    sbq.push_back(e);
    if (is_c) instruction = {1'b1, ign, a, comp_code(op), dest, jmp};
    else instruction = {1'b0, lit[W-2:0]};
    instruction_valid = 1'b1;
    in_m = mval;
    mem_ready = nm ? (lat == 0) : 1'($urandom);
    if (nm && lat > 0) begin
      repeat (lat) @(posedge clock);
      #1 mem_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    take = is_c && ((jmp[2] && $signed(res) < 0) || (jmp[1] && res == '0) ||
                    (jmp[0] && $signed(res) > 0));
    mpc = take ? ma : mpc + W'(1);
    if (!is_c) ma = {1'b0, lit[W-2:0]};
    else begin
      if (dest[2]) ma = res;
      if (dest[1]) md = res;
    end
  endtask

  task automatic a_instr(input logic [W-1:0] lit);
    run_instr(1'b0, lit, 1'b0, 0, 3'b000, 3'b000, 0, '0);
  endtask

  task automatic c_instr(input logic a, input int op, input logic [2:0] dest,
                         input logic [2:0] jmp, input int lat, input logic [W-1:0] mval);
    run_instr(1'b1, '0, a, op, dest, jmp, lat, mval);
  endtask

  task automatic gap(input int n);
    instruction_valid = 1'b0;
    instruction = W'($urandom);
    mem_ready = 1'($urandom);
    in_m = W'($urandom);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: count stall cycles, pop and compare on each commit cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall_seen = 0;
      end else if (instruction_valid && !fault) begin
        if (stall) begin
          stall_seen++;
        end else if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=commit expected=none t=%0t", $time);
        end else begin
          e = sbq.pop_front();
          if (e.chk_out) chk("out_m", out_m, e.out_m);
          chk("address_m", address_m, e.addr);
          chk("pc", pc, e.pc);
          chk("memory_load", W'(memory_load), W'(e.ml));
          chk("memory_read", W'(memory_read), W'(e.mr));
          chk("stall_cycles", W'(stall_seen), W'(e.stalls));
          stall_seen = 0;
        end
      end else if (!instruction_valid) begin
        chk("idle_load", W'(memory_load), '0);
        chk("idle_read", W'(memory_read), '0);
        chk("idle_stall", W'(stall), '0);
      end
    end
  end

  initial begin
    logic [W-1:0] sv_pc, sv_a, sv_d;
    reset = 1'b1;
    instruction_valid = 1'b0;
    instruction = '0;
    in_m = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clock);
    chk("rst_pc", pc, '0);
    chk("rst_address_m", address_m, '0);
    chk("rst_fault", W'(fault), '0);
    chk("rst_stall", W'(stall), '0);
    @(posedge clock);
    #1;

    // Sequential pc, then hold while invalid.
    a_instr(W'(5)); a_instr(W'(6)); a_instr(W'(9));
    gap(2);
    a_instr(W'(10));
    // D=A then D=D+A nine times.
    c_instr(1'b0, 4, 3'b010, 3'b000, 0, '0);
    for (int i = 0; i < 9; i++) c_instr(1'b0, 13, 3'b010, 3'b000, 0, '0);
    // @3, D=A, M=D+M with two wait cycles.
    a_instr(W'(3));
    c_instr(1'b0, 4, 3'b010, 3'b000, 0, '0);
    c_instr(1'b1, 13, 3'b001, 3'b000, 2, W'(4));
    // Jump conditions: only the last of each set jumps.
    a_instr(W'(7));
    c_instr(1'b0, 0, 3'b000, 3'b100, 0, '0);
    c_instr(1'b0, 1, 3'b000, 3'b100, 0, '0);
    c_instr(1'b0, 2, 3'b000, 3'b100, 0, '0);
    a_instr(W'(7));
    c_instr(1'b0, 2, 3'b000, 3'b010, 0, '0);
    c_instr(1'b0, 1, 3'b000, 3'b010, 0, '0);
    c_instr(1'b0, 0, 3'b000, 3'b010, 0, '0);
    a_instr(W'(7));
    c_instr(1'b0, 2, 3'b000, 3'b001, 0, '0);
    c_instr(1'b0, 0, 3'b000, 3'b001, 0, '0);
    c_instr(1'b0, 1, 3'b000, 3'b001, 0, '0);
    // Width boundaries: max literal, pc wrap, A wrap.
    a_instr(W'(24'h7FFFFF));
    c_instr(1'b0, 2, 3'b100, 3'b000, 0, '0);
    c_instr(1'b0, 0, 3'b000, 3'b111, 0, '0);
    c_instr(1'b0, 0, 3'b000, 3'b000, 0, '0);
    c_instr(1'b0, 10, 3'b100, 3'b000, 0, '0);
    a_instr(W'(1));

    // Randomised traffic with occasional idle gaps and long waits.
    for (int i = 0; i < 250; i++) begin
      int lat;
      lat = ($urandom_range(0, 9) == 0) ? MW : $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a_instr(W'($urandom));
      else c_instr(1'($urandom), $urandom_range(0, 17), 3'($urandom), 3'($urandom),
                   lat, W'($urandom));
      if ($urandom_range(0, 7) == 0) gap($urandom_range(1, 2));
    end

    // Reset during a wait aborts the pending store.
    instruction = {1'b1, 10'd0, 1'b0, comp_code(3), 3'b001, 3'b000};
    instruction_valid = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk("wait_stall", W'(stall), W'(1));
    reset = 1'b1;
    instruction_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    chk("abort_pc", pc, '0);
    chk("abort_address_m", address_m, '0);

    // Timeout into FAULT with M=D and mem_ready never high.
    a_instr(W'(16'h1234));
    c_instr(1'b0, 4, 3'b010, 3'b000, 0, '0);
    a_instr(W'(16'h0055));
    sv_pc = mpc; sv_a = ma; sv_d = md;
    instruction = {1'b1, 10'd0, 1'b0, comp_code(3), 3'b001, 3'b000};
    instruction_valid = 1'b1;
    mem_ready = 1'b0;
    repeat (MW) @(posedge clock);
    #1 chk("pre_fault", W'(fault), '0);
    chk("pre_fault_stall", W'(stall), W'(1));
    @(posedge clock);
    #1 chk("fault", W'(fault), W'(1));
    chk("fault_load", W'(memory_load), '0);
    chk("fault_stall", W'(stall), '0);
    chk("fault_pc", pc, sv_pc);
    chk("fault_address_m", address_m, sv_a);
    chk("fault_d", out_m, sv_d);
    mem_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk("fault_sticky", W'(fault), W'(1));
    chk("fault_pc_hold", pc, sv_pc);
    reset = 1'b1;
    instruction_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("post_reset_fault", W'(fault), '0);
    chk("post_reset_pc", pc, '0);
    chk("sb_drained", W'(sbq.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_wait.md
CPU_WAIT -- requirements
Module: cpu_wait

Interface
REQ-001 Parameter WIDTH, default 16, datapath/instruction/address width; legal values >= 16.
REQ-002 Parameter MAX_WAIT, default 8, wait cycles allowed for mem_ready before fault; legal values >= 1.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instruction  input  WIDTH  current instruction word.
REQ-006 instruction_valid  input  1  instruction is present and held stable until committed.
REQ-007 in_m  input  WIDTH  data-memory read value at address_m.
REQ-008 mem_ready  input  1  data memory completes the current read/write this cycle.
REQ-009 out_m  output  WIDTH  ALU result, combinational.
REQ-010 address_m  output  WIDTH  register A contents.
REQ-011 memory_load  output  1  write out_m to address_m this cycle.
REQ-012 memory_read  output  1  in_m is consumed this cycle.
REQ-013 pc  output  WIDTH  program counter.
REQ-014 stall  output  1  a valid instruction is held waiting on memory.
REQ-015 fault  output  1  sticky memory-timeout indication.

Function
REQ-016 Decode: bit WIDTH-1 = 0 is an A-instruction, which loads instruction[WIDTH-2:0], zero-extended, into A; bit WIDTH-1 = 1 is a C-instruction: bit 12 a, bits 11:6 zx nx zy ny f no, bits 5:3 dest A D M, bits 2:0 jump lt eq gt; bits WIDTH-2:13 ignored.
REQ-017 ALU: Hack semantics on D and (a ? in_m : A), WIDTH-bit two's complement, overflow discarded; zr = out==0; ng = out[WIDTH-1].
REQ-018 needs_mem = C-instruction and (a==1 or dest M).
REQ-019 memory_load = C and dest M and instruction_valid and state RUN/WAIT; memory_read = C and a==1 under the same conditions.
REQ-020 Commit (A/D/pc update) occurs on an edge where instruction_valid and state is RUN or WAIT and (not needs_mem or mem_ready).
REQ-021 Without instruction_valid, A, D and pc hold.
REQ-022 Commit: dest A loads out_m (C) or literal (A-instr); dest D loads out_m; A and D are loaded from the same out_m on the same edge.
REQ-023 Jump taken when (lt and ng) or (eq and zr) or (gt and not ng and not zr); pc <= pre-edge A if taken, else pc+1, wrapping from all-ones to 0.
REQ-024 FSM states RUN, WAIT, FAULT.
REQ-025 RUN: valid and needs_mem and not mem_ready -> WAIT, wait_cnt <= 1; otherwise stay in RUN (zero-wait commit when mem_ready is already high).
REQ-026 WAIT: mem_ready -> commit, RUN; else if wait_cnt == MAX_WAIT -> FAULT, no commit; else wait_cnt+1.
REQ-027 FAULT: no commits; memory_load, memory_read and stall are 0; fault = 1; leaves only on reset.
REQ-028 stall = instruction_valid and needs_mem and not mem_ready and state is RUN or WAIT.

Reset
REQ-029 On reset edge: A=0, D=0, pc=0, wait_cnt=0, state RUN, fault=0; reset overrides commit, jump and FAULT.
REQ-030 Reset during WAIT aborts the pending instruction without committing it.

Structure
REQ-031 Shared package holds the FSM state enum, the bit-position constants for a/comp/dest/jump, and the default WIDTH/MAX_WAIT values.
REQ-032 ALU is one sub-module, alu, parametrised by WIDTH; the register, pc and FSM logic live in cpu_wait.

Verification
REQ-033 Reset, then 3 valid no-mem cycles -> pc 0,1,2,3; instruction_valid=0 for 2 cycles -> pc holds.
REQ-034 @10, D=A, then D=D+A x9 -> out_m 20..100 in steps of 10; memory_load=0, stall=0 throughout.
REQ-035 @3, D=A, M=D+M with in_m=4 and mem_ready low for 2 cycles -> stall=1 for 2 cycles, memory_load=1, out_m=7; pc advances only on the mem_ready edge.
REQ-036 @7 then 0;JLT, 1;JLT, -1;JLT -> pc 2,3,7; repeat for JEQ with -1,1,0 and JGT with -1,0,1 -> pc 7 only on the last of each set.
REQ-037 WIDTH=24: A-instruction 0x7FFFFF -> address_m 0x7FFFFF; pc forced to 0xFFFFFF then a no-jump commit -> pc 0; A=A+1 from 0xFFFFFF -> 0.
REQ-038 M=D with mem_ready never high and MAX_WAIT=8 -> fault=1 after 8 wait cycles, pc/A/D unchanged, memory_load=0; reset -> fault=0, pc=0.
